// File: rtl/lcd_pattern_gen_if.sv
// Pixel-request bus between the LCD screen driver and the pattern generator.
// The driver (master) supplies coordinates and a consume strobe; the generator returns pixel and status.
interface lcd_pattern_gen_if;
  logic        flush_data_update_i;
  logic [15:0] flush_addr_width_i;
  logic [15:0] flush_addr_height_i;
  logic [15:0] flush_data_o;
  logic [1:0]  mode_o;
  logic [15:0] frame_cnt_o;

  modport master (
    output flush_data_update_i, flush_addr_width_i, flush_addr_height_i,
    input  flush_data_o, mode_o, frame_cnt_o
  );

  modport slave (
    input  flush_data_update_i, flush_addr_width_i, flush_addr_height_i,
    output flush_data_o, mode_o, frame_cnt_o
  );
endinterface

// File: rtl/lcd_pattern_gen.sv
// Test-pattern source for an LCD driver: four selectable RGB565 patterns, a debounced
// mode button applied at frame boundaries, and a bouncing box animated once per frame.
module lcd_pattern_gen #(
  parameter logic [31:0] SCREEN_WIDTH    = 32'd320,
  parameter logic [31:0] SCREEN_HEIGHT   = 32'd240,
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1_000_000,
  parameter logic [31:0] BOX_SIZE        = 32'd32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_n,
  lcd_pattern_gen_if.slave   bus
);

  localparam logic [15:0] W16      = 16'(SCREEN_WIDTH);
  localparam logic [15:0] H16      = 16'(SCREEN_HEIGHT);
  localparam logic [15:0] BOX16    = 16'(BOX_SIZE);
  localparam logic [15:0] LIM_X    = 16'(SCREEN_WIDTH - BOX_SIZE);
  localparam logic [15:0] LIM_Y    = 16'(SCREEN_HEIGHT - BOX_SIZE);
  localparam logic [15:0] BAR_W    = 16'(SCREEN_WIDTH / 32'd8);
  localparam logic [31:0] DEB_LAST = DEBOUNCE_CYCLES - 32'd1;

  logic [15:0] x, y, bar;
  logic        frame_start, press;
  logic        key_s1_q, key_s2_q, stable_q, stable_d;
  logic [31:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]  pend_q, pend_d, mode_q;
  logic [15:0] frame_cnt_q, pixel_q, pixel_d;
  logic [15:0] bx_q, bx_d, by_q, by_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic        in_box;

  // Returns {next_dir, next_pos}; dir = 1 means moving toward lim.
  function automatic logic [16:0] step_pos(input logic [15:0] pos, input logic dir,
                                           input logic [15:0] lim);
    if (dir) begin
      if (pos >= lim - 16'd2) step_pos = {1'b0, lim};
      else                    step_pos = {1'b1, pos + 16'd2};
    end else begin
      if (pos <= 16'd2)       step_pos = {1'b1, 16'd0};
      else                    step_pos = {1'b0, pos - 16'd2};
    end
  endfunction

  assign x           = bus.flush_addr_width_i;
  assign y           = bus.flush_addr_height_i;
  assign frame_start = bus.flush_data_update_i && (x == 16'd0) && (y == 16'd0);
  assign bar         = x / BAR_W;
  assign in_box      = (x >= bx_q) && (x < bx_q + BOX16) && (y >= by_q) && (y < by_q + BOX16);

  always_comb begin
    pixel_d = 16'h0000;
    if (x < W16 && y < H16) begin
      case (mode_q)
        2'd0: begin
          case (bar)
            16'd0:   pixel_d = 16'hFFFF;
            16'd1:   pixel_d = 16'hFFE0;
            16'd2:   pixel_d = 16'h07FF;
            16'd3:   pixel_d = 16'h07E0;
            16'd4:   pixel_d = 16'hF81F;
            16'd5:   pixel_d = 16'hF800;
            16'd6:   pixel_d = 16'h001F;
            default: pixel_d = 16'h0000;
          endcase
        end
        2'd1:    pixel_d = (x[4] ^ y[4]) ? 16'hFFFF : 16'h0000;
        2'd2:    pixel_d = {x[8:4], y[7:2], 5'b00000};
        default: pixel_d = in_box ? 16'hFFFF : 16'h001F;
      endcase
    end
  end

  // A press is the stable level falling 1 -> 0 once the synchronised key has held long enough.
  always_comb begin
    deb_cnt_d = deb_cnt_q + 32'd1;
    stable_d  = stable_q;
    press     = 1'b0;
    if (key_s2_q == stable_q) begin
      deb_cnt_d = 32'd0;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_cnt_d = 32'd0;
      stable_d  = key_s2_q;
      press     = stable_q & ~key_s2_q;
    end
    pend_d = press ? pend_q + 2'd1 : pend_q;
  end

  always_comb begin
    {dx_d, bx_d} = {dx_q, bx_q};
    {dy_d, by_d} = {dy_q, by_q};
    if (frame_start) begin
      {dx_d, bx_d} = step_pos(bx_q, dx_q, LIM_X);
      {dy_d, by_d} = step_pos(by_q, dy_q, LIM_Y);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_s1_q    <= 1'b1;
      key_s2_q    <= 1'b1;
      stable_q    <= 1'b1;
      deb_cnt_q   <= 32'd0;
      pend_q      <= 2'd0;
      mode_q      <= 2'd0;
      frame_cnt_q <= 16'd0;
      pixel_q     <= 16'h0000;
      bx_q        <= 16'd0;
      by_q        <= 16'd0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
    end else begin
      key_s1_q  <= key_n;
      key_s2_q  <= key_s1_q;
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
      pend_q    <= pend_d;
      pixel_q   <= pixel_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      if (frame_start) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
        mode_q      <= pend_q;
      end
    end
  end

  assign bus.flush_data_o = pixel_q;
  assign bus.mode_o       = mode_q;
  assign bus.frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen: stimulus queues hand-computed expectations,
// a monitor compares them one cycle after the coordinate or strobe is applied.
module tb_lcd_pattern_gen;
  localparam int DEB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_n = 1'b1;

  lcd_pattern_gen_if dif ();

  lcd_pattern_gen #(
    .SCREEN_WIDTH(32'd320), .SCREEN_HEIGHT(32'd240),
    .DEBOUNCE_CYCLES(32'(DEB)), .BOX_SIZE(32'd32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .bus(dif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          sel;
    logic [15:0] exp;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vid = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  function automatic string sel_name(input int s);
    case (s)
      0:       sel_name = "pixel";
      1:       sel_name = "mode";
      default: sel_name = "frame_cnt";
    endcase
  endfunction

  // Monitor: compare every entry whose due cycle has arrived.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        case (e.sel)
          0:       act = dif.flush_data_o;
          1:       act = {14'd0, dif.mode_o};
          default: act = dif.frame_cnt_o;
        endcase
        n_vec++;
        if (e.due != cyc || act !== e.exp) begin
          n_err++;
          $display("FAIL %s vec %0d: got %h, expected %h (due %0d, cycle %0d)",
                   sel_name(e.sel), e.id, act, e.exp, e.due, cyc);
        end
      end
    end
  end

  task automatic push(input int sel, input logic [15:0] e);
    sb.push_back('{cyc + 1, sel, e, vid});
    vid++;
  endtask

  task automatic px(input int x, input int y, input logic [15:0] e);
    @(negedge clk);
    dif.flush_data_update_i = 1'b0;
    dif.flush_addr_width_i  = 16'(x);
    dif.flush_addr_height_i = 16'(y);
    push(0, e);
  endtask

  task automatic frame(input int em, input int efc, input bit chk);
    @(negedge clk);
    dif.flush_data_update_i = 1'b1;
    dif.flush_addr_width_i  = 16'd0;
    dif.flush_addr_height_i = 16'd0;
    if (chk) begin
      push(1, 16'(em));
      push(2, 16'(efc));
    end
    @(negedge clk);
    dif.flush_data_update_i = 1'b0;
  endtask

  task automatic press(input int hold);
    @(negedge clk);
    key_n = 1'b0;
    repeat (hold) @(negedge clk);
    key_n = 1'b1;
    repeat (2 * DEB + 4) @(negedge clk);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    dif.flush_addr_width_i  = 16'd291;
    dif.flush_addr_height_i = 16'd171;
    push(0, 16'h0000);
    push(1, 16'd0);
    push(2, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Press whose registration lands on the same edge as a (0,0) strobe.
  task automatic press_on_frame(input int em, input int efc);
    @(negedge clk);
    key_n = 1'b0;
    repeat (DEB + 1) @(negedge clk);
    dif.flush_data_update_i = 1'b1;
    dif.flush_addr_width_i  = 16'd0;
    dif.flush_addr_height_i = 16'd0;
    push(1, 16'(em));
    push(2, 16'(efc));
    @(negedge clk);
    dif.flush_data_update_i = 1'b0;
    repeat (4) @(negedge clk);
    key_n = 1'b1;
    repeat (2 * DEB + 4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.flush_data_update_i = 1'b0;
    dif.flush_addr_width_i  = 16'd5;
    dif.flush_addr_height_i = 16'd5;
    repeat (2) @(negedge clk);
    push(0, 16'h0000);
    push(1, 16'd0);
    push(2, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode 0 colour bars and out-of-range blanking
    for (int x = 0; x < 320; x++) px(x, 10, bars[x / 40]);
    px(320, 10, 16'h0000);
    px(10, 240, 16'h0000);
    px(279, 239, 16'h001F);

    press(DEB / 2);
    frame(0, 1, 1'b1);
    press(DEB + 6);
    @(negedge clk);
    push(1, 16'd0);
    frame(1, 2, 1'b1);

    // Mode 1 checkerboard
    px(16, 0, 16'hFFFF);
    px(16, 16, 16'h0000);
    px(320, 5, 16'h0000);
    px(0, 16, 16'hFFFF);
    px(31, 15, 16'hFFFF);
    px(32, 0, 16'h0000);

    press(DEB + 6);
    frame(2, 3, 1'b1);
    // Mode 2 gradient
    px(291, 171, 16'h9540);
    px(319, 239, 16'h9F60);
    px(16, 4, 16'h0820);
    frame(2, 4, 1'b1);
    frame(2, 5, 1'b1);

    rst_pulse();
    px(50, 171, 16'hFFE0);
    frame(0, 1, 1'b1);
    press_on_frame(0, 2);
    frame(1, 3, 1'b1);
    press(DEB + 6);
    press(DEB + 6);
    frame(3, 4, 1'b1);
    px(8, 8, 16'hFFFF);
    px(40, 8, 16'h001F);
    px(7, 8, 16'h001F);

    // Moving box from a fresh reset
    rst_pulse();
    press(DEB + 6);
    press(DEB + 6);
    press(DEB + 6);
    for (int i = 1; i <= 144; i++) frame(3, i, (i == 1) || (i == 144));
    px(288, 128, 16'hFFFF);
    px(287, 128, 16'h001F);
    px(319, 159, 16'hFFFF);
    px(288, 160, 16'h001F);
    frame(3, 145, 1'b1);
    px(286, 126, 16'hFFFF);
    px(318, 126, 16'h001F);
    px(285, 126, 16'h001F);
    px(317, 157, 16'hFFFF);
    px(286, 158, 16'h001F);

    press(DEB + 6);
    frame(0, 146, 1'b1);

    // Strobe away from the origin is not a frame start
    @(negedge clk);
    dif.flush_data_update_i = 1'b1;
    dif.flush_addr_width_i  = 16'd5;
    dif.flush_addr_height_i = 16'd0;
    push(2, 16'd146);
    @(negedge clk);
    dif.flush_data_update_i = 1'b0;

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
